// File: rtl/burst_addr_gen.sv
// Burst address generator: emits base + k*stride for each beat on a valid/ready stream.
// Optional repeating (wrap) bursts are enabled by defining BURST_GEN_WRAP_EN.
module burst_addr_gen #(
  parameter int W     = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     base_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [W-1:0]     stride_in,
  input  logic             wrap_in,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     addr,
  output logic [W-1:0]     base,
  output logic [LEN_W-1:0] cnt,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     wraps
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     addr_q, addr_d;
  logic [W-1:0]     base_q, base_d;
  logic [W-1:0]     stride_q, stride_d;
  logic [W-1:0]     wraps_q, wraps_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             wrap_sel;
  logic             at_last;

`ifdef BURST_GEN_WRAP_EN
  assign wrap_sel = wrap_in;
`else
  // Without repeat support every burst is single-shot; wrap_q stays 0 so wraps never counts.
  logic unused_wrap_in;
  assign unused_wrap_in = wrap_in;
  assign wrap_sel       = 1'b0;
`endif

  assign at_last = (cnt_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    base_d   = base_q;
    stride_d = stride_q;
    wraps_d  = wraps_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    wrap_d   = wrap_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      // abort in IDLE suppresses a same-cycle start; zero-length requests are dropped.
      if (!abort && start && (len_in != '0)) begin
        state_d  = RUN;
        base_d   = base_in;
        addr_d   = base_in;
        len_d    = len_in;
        stride_d = stride_in;
        wrap_d   = wrap_sel;
        cnt_d    = '0;
        wraps_d  = '0;
      end
    end else begin
      if (abort) begin
        state_d = IDLE;
      end else if (out_ready) begin
        if (!at_last) begin
          addr_d = addr_q + stride_q;
          cnt_d  = cnt_q + LEN_W'(1);
        end else if (wrap_q) begin
          addr_d = base_q;
          cnt_d  = '0;
          if (wraps_q != '1) begin
            wraps_d = wraps_q + W'(1);
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      wraps_q  <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      wraps_q  <= wraps_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign last      = (state_q == RUN) && at_last;
  assign addr      = addr_q;
  assign base      = base_q;
  assign cnt       = cnt_q;
  assign done      = done_q;
  assign wraps     = wraps_q;

endmodule

// File: tb/tb_burst_addr_gen.sv
// Directed bench for burst_addr_gen with a scoreboard of expected beats.
module tb_burst_addr_gen;
  localparam int W     = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     base_in;
  logic [LEN_W-1:0] len_in;
  logic [W-1:0]     stride_in;
  logic             wrap_in;
  logic             abort;
  logic             out_ready;
  logic             out_valid;
  logic [W-1:0]     addr;
  logic [W-1:0]     base;
  logic [LEN_W-1:0] cnt;
  logic             last;
  logic             busy;
  logic             done;
  logic [W-1:0]     wraps;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]     addr;
    logic [LEN_W-1:0] cnt;
    logic             last;
  } beat_t;
  beat_t sb_q[$];

  burst_addr_gen #(.W(W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_in(base_in), .len_in(len_in),
    .stride_in(stride_in), .wrap_in(wrap_in), .abort(abort), .out_ready(out_ready),
    .out_valid(out_valid), .addr(addr), .base(base), .cnt(cnt), .last(last),
    .busy(busy), .done(done), .wraps(wraps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats of a burst, repeated over passes when nbeats exceeds len.
  task automatic push_burst(input logic [W-1:0] b, input logic [W-1:0] s,
                            input int len, input int nbeats);
    beat_t e;
    for (int i = 0; i < nbeats; i++) begin
      int c;
      c = i % len;
      e.addr = b + W'(c) * s;
      e.cnt  = LEN_W'(c);
      e.last = (c == len - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [W-1:0] b, input logic [LEN_W-1:0] l,
                          input logic [W-1:0] s, input logic w);
    out_ready = 1'b0;
    base_in = b; len_in = l; stride_in = s; wrap_in = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One stream cycle: compare presented beat to the scoreboard head, pop on handshake.
  task automatic beat(input logic rdy, input string tag);
    beat_t e;
    out_ready = rdy;
    #2;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=no_expected_beat expected=queued_beat", tag);
    end else begin
      if (rdy) e = sb_q.pop_front();
      else     e = sb_q[0];
      chk({tag, "_addr"}, 32'(addr), 32'(e.addr));
      chk({tag, "_cnt"},  32'(cnt),  32'(e.cnt));
      chk({tag, "_last"}, 32'(last), 32'(e.last));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_in = '0; len_in = '0; stride_in = '0;
    wrap_in = 1'b0; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0); chk("rst_addr", 32'(addr), 0);
    chk("rst_base", 32'(base), 0);       chk("rst_cnt", 32'(cnt), 0);
    chk("rst_last", 32'(last), 0);       chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);       chk("rst_wraps", 32'(wraps), 0);
    rst = 1'b0;

    // Reset in the middle of a burst
    do_start(16'h1000, 8'd4, 16'd4, 1'b0);
    push_burst(16'h1000, 16'd4, 4, 2);
    beat(1'b1, "mid_b0");
    beat(1'b1, "mid_b1");
    chk("mid_cnt_before_rst", 32'(cnt), 2);
    out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 0); chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_base", 32'(base), 0);       chk("mid_rst_cnt", 32'(cnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);       chk("mid_rst_last", 32'(last), 0);

    // Single-shot burst with ready held high, then back-to-back start in the done cycle
    do_start(16'h8000, 8'd3, 16'd2, 1'b0);
    chk("ss_start_addr", 32'(addr), 32'h8000);
    chk("ss_start_base", 32'(base), 32'h8000);
    push_burst(16'h8000, 16'd2, 3, 3);
    beat(1'b1, "ss_b0"); beat(1'b1, "ss_b1"); beat(1'b1, "ss_b2");
    chk("ss_done", 32'(done), 1);    chk("ss_busy_off", 32'(busy), 0);
    chk("ss_valid_off", 32'(out_valid), 0);
    chk("ss_addr_hold", 32'(addr), 32'h8004); chk("ss_cnt_hold", 32'(cnt), 2);
    do_start(16'h0020, 8'd1, 16'd0, 1'b0);
    chk("b2b_busy", 32'(busy), 1); chk("b2b_done_clr", 32'(done), 0);
    push_burst(16'h0020, 16'd0, 1, 1);
    beat(1'b1, "b2b_b0");
    chk("b2b_done", 32'(done), 1);
    @(negedge clk);
    chk("b2b_done_pulse", 32'(done), 0);

    // Backpressure with address overflow past 2^W
    do_start(16'hFFFE, 8'd4, 16'd1, 1'b0);
    push_burst(16'hFFFE, 16'd1, 4, 4);
    beat(1'b1, "bp0"); beat(1'b0, "bp1"); beat(1'b1, "bp2");
    beat(1'b1, "bp3"); beat(1'b0, "bp4"); beat(1'b1, "bp5");
    chk("bp_done", 32'(done), 1); chk("bp_addr_final", 32'(addr), 32'h0001);
    @(negedge clk);

    // Zero-length request is ignored
    do_start(16'h4444, 8'd0, 16'd1, 1'b0);
    chk("len0_busy", 32'(busy), 0); chk("len0_base", 32'(base), 32'hFFFE);
    chk("len0_addr", 32'(addr), 32'h0001);

    // abort blocks a same-cycle start in IDLE
    abort = 1'b1;
    do_start(16'h5555, 8'd5, 16'd1, 1'b0);
    abort = 1'b0;
    chk("abst_busy", 32'(busy), 0); chk("abst_base", 32'(base), 32'hFFFE);

    // start during RUN is ignored; abort together with the last handshake gives no done
    do_start(16'h0100, 8'd3, 16'h0010, 1'b0);
    push_burst(16'h0100, 16'h0010, 3, 3);
    start = 1'b1; base_in = 16'h0999; len_in = 8'd7;
    beat(1'b1, "run_b0");
    start = 1'b0;
    chk("run_restart_base", 32'(base), 32'h0100);
    beat(1'b1, "run_b1");
    abort = 1'b1;
    beat(1'b1, "run_b2_abort");
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0); chk("abort_done", 32'(done), 0);
    chk("abort_addr", 32'(addr), 32'h0120); chk("abort_cnt", 32'(cnt), 2);
    @(negedge clk);
    chk("abort_done_late", 32'(done), 0);

`ifdef BURST_GEN_WRAP_EN
    do_start(16'h0010, 8'd2, 16'd8, 1'b1);
    push_burst(16'h0010, 16'd8, 2, 6);
    for (int i = 0; i < 6; i++) beat(1'b1, $sformatf("wrap_b%0d", i));
    chk("wrap_count", 32'(wraps), 3); chk("wrap_done", 32'(done), 0);
    chk("wrap_busy", 32'(busy), 1);   chk("wrap_addr", 32'(addr), 32'h0010);
    out_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("wrap_abort_busy", 32'(busy), 0); chk("wrap_abort_done", 32'(done), 0);
    chk("wrap_abort_wraps", 32'(wraps), 3);
`else
    do_start(16'h0010, 8'd2, 16'd8, 1'b1);
    push_burst(16'h0010, 16'd8, 2, 2);
    beat(1'b1, "nowrap_b0"); beat(1'b1, "nowrap_b1");
    chk("nowrap_done", 32'(done), 1); chk("nowrap_busy", 32'(busy), 0);
    chk("nowrap_wraps", 32'(wraps), 0);
`endif

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/burst_addr_gen.md
# burst_addr_gen

Parametrised burst address generator for the memory-side datapath. It loads a base address, beat count and stride on a start request. It then emits one address per beat on a valid/ready stream, tracking base, current address and beat count. It sits between the command decoder and the memory request port. It supports single-shot incrementing bursts and, optionally, continuously repeating (wrap) bursts that run until aborted.

## Interface
Parameters:
- W, 16, address/stride width
- LEN_W, 8, beat-count width; max burst = 2^LEN_W-1 beats

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  burst request; sampled only in IDLE
- base_in  in  W  burst start address
- len_in  in  LEN_W  beats in burst; 0 = request ignored
- stride_in  in  W  address increment per beat
- wrap_in  in  1  repeat mode select (see Configuration)
- abort  in  1  terminate current burst
- out_ready  in  1  sink accepts address
- out_valid  out  1  addr valid this cycle
- addr  out  W  current beat address
- base  out  W  latched base of active/last burst
- cnt  out  LEN_W  beats completed in current pass
- last  out  1  out_valid && cnt==len-1
- busy  out  1  state==RUN
- done  out  1  one-cycle pulse, single-shot burst completed
- wraps  out  W  completed passes in wrap mode, saturating at 2^W-1

## Operation
- States: IDLE, RUN. The FSM leaves no other state encoding reachable.
- Priority each cycle: rst > abort > start/handshake.
- IDLE, start=1, len_in!=0, abort=0 -> RUN. Latch base<=base_in, addr<=base_in, len/stride/wrap latched internally, cnt<=0, wraps<=0.
- IDLE, start=1, len_in==0 -> stay IDLE; no output changes.
- RUN: out_valid=1. On handshake (out_valid&&out_ready):
  - if cnt!=len-1: addr<=addr+stride (mod 2^W), cnt<=cnt+1.
  - if cnt==len-1 and single-shot: -> IDLE, done<=1, addr and cnt hold final values.
  - if cnt==len-1 and wrap: addr<=base, cnt<=0, wraps<=wraps+1 (saturating), stay RUN.
- No handshake: addr, cnt, wraps hold. out_valid stays high (no retraction).
- start while RUN: ignored. The burst is not restarted.
- abort in RUN -> IDLE next cycle, no done pulse, cnt/addr hold. Any same-cycle handshake is not counted. abort in IDLE: no effect; it also blocks a same-cycle start.
- Arithmetic: addr wraps modulo 2^W silently. Stride 0 is legal (repeated address).

## Timing
- Reset values: out_valid=0, addr=0, base=0, cnt=0, last=0, busy=0, done=0, wraps=0; state IDLE.
- Start accepted at edge T: out_valid=1, addr=base_in from cycle T+1.
- Throughput: one beat per cycle while out_ready=1. A single-shot burst of N beats with ready held high completes N+1 cycles after start.
- done is high for exactly the one cycle following the final handshake; busy=0 in that cycle. A start in that cycle is accepted (back-to-back bursts, one idle cycle between streams).
- last is combinational from state/cnt/len; all other outputs are registered.

## Configuration
- Macro BURST_GEN_WRAP_EN.
- Defined: wrap_in latched at start selects repeat mode as above.
- Not defined: wrap_in is ignored and all bursts are single-shot. The wraps port stays present, tied to 0.

## Test plan
- Reset mid-burst: start base=0x1000,len=4,stride=4; rst at beat 2 -> next cycle all outputs 0, IDLE.
- Single-shot, ready=1: base=0x8000,len=3,stride=2 -> addr 0x8000,0x8002,0x8004 on consecutive cycles; last on third; done one cycle after; busy then 0.
- Backpressure plus address overflow: base=0xFFFE,stride=1,len=4, ready toggled 1,0,1,1,0,1 -> addr sequence 0xFFFE,0xFFFF,0x0000,0x0001, each held during ready=0; cnt holds.
- Wrap mode (macro defined): base=0x10,len=2,stride=8,wrap=1, ready=1 for 6 cycles -> addr 0x10,0x18,0x10,0x18,0x10,0x18; wraps=3 after the final handshake; no done. abort -> IDLE next cycle.
- Corner requests: len_in=0 start -> stays IDLE. start during RUN -> ignored. abort+start same cycle in IDLE -> stays IDLE. Handshake+abort on last beat -> no done.
- Macro undefined: wrap=1, len=2 -> behaves single-shot, done pulses, wraps=0.
